// File: rtl/burst_writer_pkg.sv
// Shared types and defaults for the burst_writer FIFO write-side burst source.
package burst_writer_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned LEN_W_DEF  = 4;

    localparam logic [DATA_W_DEF-1:0] DATA_1_RST = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CSUM = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/burst_writer.sv
// Burst source for the FIFO write port: seed, seed+step, ... under buffer_full backpressure.
// Define BURST_WRITER_CHECKSUM_EN to append a trailing XOR checksum word to every burst.
module burst_writer
    import burst_writer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    burst_len,
    input  logic [DATA_W-1:0]   seed,
    input  logic [DATA_W-1:0]   step,
    input  logic                buffer_full,
    output logic [DATA_W-1:0]   data_1,
    output logic                data_1_en,
    output logic                busy,
    output logic                done,
    output logic [LEN_W:0]      words_sent
);

    localparam int unsigned WS_W = LEN_W + 1;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_1_q, data_1_d;
    logic                data_1_en_q, data_1_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WS_W-1:0]     words_sent_q, words_sent_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   step_q, step_d;
`ifdef BURST_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif
    logic                accept_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            data_1_q     <= DATA_W'(DATA_1_RST);
            data_1_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            words_sent_q <= '0;
            remaining_q  <= '0;
            step_q       <= '0;
`ifdef BURST_WRITER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            data_1_q     <= data_1_d;
            data_1_en_q  <= data_1_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            words_sent_q <= words_sent_d;
            remaining_q  <= remaining_d;
            step_q       <= step_d;
`ifdef BURST_WRITER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    // Next-state and datapath; buffer_full only gates acceptance of the offered word
    always_comb begin
        state_d      = state_q;
        data_1_d     = data_1_q;
        data_1_en_d  = data_1_en_q;
        words_sent_d = words_sent_q;
        remaining_d  = remaining_q;
        step_d       = step_q;
`ifdef BURST_WRITER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        accept_c     = data_1_en_q && !buffer_full;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_1_d     = seed;
                    data_1_en_d  = 1'b1;
                    remaining_d  = burst_len;
                    step_d       = step;
                    words_sent_d = '0;
`ifdef BURST_WRITER_CHECKSUM_EN
                    checksum_d   = '0;
`endif
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    words_sent_d = words_sent_q + WS_W'(1);
`ifdef BURST_WRITER_CHECKSUM_EN
                    checksum_d   = checksum_q ^ data_1_q;
`endif
                    if (remaining_q != '0) begin
                        data_1_d    = data_1_q + step_q;
                        remaining_d = remaining_q - LEN_W'(1);
                    end else begin
`ifdef BURST_WRITER_CHECKSUM_EN
                        // Trailing word folds in the payload word being accepted now
                        data_1_d    = checksum_q ^ data_1_q;
                        state_d     = ST_CSUM;
`else
                        data_1_en_d = 1'b0;
                        state_d     = ST_DONE;
`endif
                    end
                end
            end
`ifdef BURST_WRITER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_c) begin
                    words_sent_d = words_sent_q + WS_W'(1);
                    data_1_en_d  = 1'b0;
                    state_d      = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                data_1_en_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_CSUM);
        done_d = (state_d == ST_DONE);
    end

    assign data_1     = data_1_q;
    assign data_1_en  = data_1_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_burst_writer.sv
// Directed bench for burst_writer: table of bursts plus reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_burst_writer;

`ifdef BURST_WRITER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  burst_len = '0;
    logic [15:0] seed = '0;
    logic [15:0] step = '0;
    logic        buffer_full = 1'b0;
    logic [15:0] data_1;
    logic        data_1_en;
    logic        busy;
    logic        done;
    logic [4:0]  words_sent;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  len;
        logic [15:0] seed;
        logic [15:0] step;
        int          stall_idx;
        int          stall_cycles;
        int          n_payload;
        logic [15:0] exp_last;
        logic [15:0] exp_csum;
        bit          hold_start;
    } vec_t;

    vec_t vecs[5];

    burst_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .burst_len  (burst_len),
        .seed       (seed),
        .step       (step),
        .buffer_full(buffer_full),
        .data_1     (data_1),
        .data_1_en  (data_1_en),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " drain_done"}, 32'(done), 32'd1);
    endtask

    task automatic do_burst(input vec_t v, input string tag);
        logic [15:0] got[$];
        logic [15:0] m;
        int j, idx, stall_left, done_j;
        bit seen;
        @(negedge clk);
        start = 1'b1; burst_len = v.len; seed = v.seed; step = v.step; buffer_full = 1'b0;
        @(posedge clk);
        #1;
        if (!v.hold_start) start = 1'b0;
        idx = 0; stall_left = v.stall_cycles; seen = 1'b0; done_j = -1; j = 0;
        while (!seen && j < 200) begin
            @(negedge clk);
            if (j == 0) begin
                chk({tag, " first_en"}, 32'(data_1_en), 32'd1);
                chk({tag, " first_busy"}, 32'(busy), 32'd1);
                chk({tag, " ws_cleared"}, 32'(words_sent), 32'd0);
            end
            if (done) begin
                seen = 1'b1;
                done_j = j;
            end else begin
                if (data_1_en && idx == v.stall_idx && stall_left > 0) begin
                    buffer_full = 1'b1;
                    stall_left--;
                end else begin
                    buffer_full = 1'b0;
                end
                if (data_1_en && !buffer_full) begin
                    got.push_back(data_1);
                    idx++;
                end
            end
            j++;
        end
        buffer_full = 1'b0;
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " done_cycle"}, 32'(done_j), 32'(v.n_payload + CS + v.stall_cycles));
        chk({tag, " words_sent"}, 32'(words_sent), 32'(v.n_payload + CS));
        chk({tag, " en_at_done"}, 32'(data_1_en), 32'd0);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " word_count"}, 32'(got.size()), 32'(v.n_payload + CS));
        for (int i = 0; i < got.size() && i < v.n_payload; i++) begin
            m = 16'(v.seed + 16'(i) * v.step);
            chk({tag, $sformatf(" word%0d", i)}, 32'(got[i]), 32'(m));
        end
        if (got.size() >= v.n_payload)
            chk({tag, " last_payload"}, 32'(got[v.n_payload-1]), 32'(v.exp_last));
`ifdef BURST_WRITER_CHECKSUM_EN
        if (got.size() > v.n_payload)
            chk({tag, " csum_word"}, 32'(got[v.n_payload]), 32'(v.exp_csum));
`endif
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " ws_held"}, 32'(words_sent), 32'(v.n_payload + CS));
        if (v.hold_start) begin
            // DONE ignored start; IDLE samples it and the next burst shows one cycle later
            chk({tag, " idle_gap_en"}, 32'(data_1_en), 32'd0);
            @(negedge clk);
            chk({tag, " rerun_en"}, 32'(data_1_en), 32'd1);
            chk({tag, " rerun_data"}, 32'(data_1), 32'(v.seed));
            start = 1'b0;
            wait_done({tag, " rerun"});
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{len: 4'd3,  seed: 16'h0010, step: 16'h0002, stall_idx: -1, stall_cycles: 0,
                    n_payload: 4,  exp_last: 16'h0016, exp_csum: 16'h0000, hold_start: 1'b0};
        vecs[1] = '{len: 4'd3,  seed: 16'h0010, step: 16'h0002, stall_idx: 1,  stall_cycles: 3,
                    n_payload: 4,  exp_last: 16'h0016, exp_csum: 16'h0000, hold_start: 1'b0};
        vecs[2] = '{len: 4'd1,  seed: 16'hFFFF, step: 16'h0001, stall_idx: -1, stall_cycles: 0,
                    n_payload: 2,  exp_last: 16'h0000, exp_csum: 16'hFFFF, hold_start: 1'b0};
        vecs[3] = '{len: 4'd15, seed: 16'h0003, step: 16'h0001, stall_idx: -1, stall_cycles: 0,
                    n_payload: 16, exp_last: 16'h0012, exp_csum: 16'h0010, hold_start: 1'b0};
        vecs[4] = '{len: 4'd2,  seed: 16'hA000, step: 16'h0F00, stall_idx: 2,  stall_cycles: 1,
                    n_payload: 3,  exp_last: 16'hBE00, exp_csum: 16'hB100, hold_start: 1'b1};

        #12;
        chk("rst data_1", 32'(data_1), 32'd0);
        chk("rst en", 32'(data_1_en), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst ws", 32'(words_sent), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++)
            do_burst(vecs[k], $sformatf("vec%0d", k));

        // Reset after two accepted words abandons the burst immediately
        @(negedge clk);
        start = 1'b1; burst_len = 4'd7; seed = 16'h0100; step = 16'h0001;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst ws_before", 32'(words_sent), 32'd2);
        chk("midrst data_before", 32'(data_1), 32'h0102);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst en", 32'(data_1_en), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst data", 32'(data_1), 32'd0);
        chk("midrst ws", 32'(words_sent), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_burst('{len: 4'd2, seed: 16'h5555, step: 16'h1111, stall_idx: -1, stall_cycles: 0,
                   n_payload: 3, exp_last: 16'h7777, exp_csum: 16'h4444, hold_start: 1'b0},
                 "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_writer.md
# burst_writer

Single-clock burst source for the write side of the team's 16-bit FIFO wrapper. On a `start` pulse it emits a burst of `burst_len+1` words (`seed`, `seed+step`, …) on `data_1`/`data_1_en`. It honours the FIFO's `buffer_full` backpressure so that no word is dropped. It sits in the producer clock domain, directly upstream of the FIFO write port.

## Interface
Parameters:
- `DATA_W`, 16, word width; matches the FIFO data width.
- `LEN_W`, 4, width of `burst_len`; a burst carries 1..2^LEN_W payload words.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  burst request; sampled only in IDLE.
- `burst_len`  in  LEN_W  payload word count minus 1; latched on start.
- `seed`  in  DATA_W  first payload word; latched on start.
- `step`  in  DATA_W  increment between payload words; latched on start.
- `buffer_full`  in  1  FIFO full flag; a word is accepted only when `data_1_en && !buffer_full` at a rising edge.
- `data_1`  out  DATA_W  word offered to the FIFO; registered.
- `data_1_en`  out  1  write enable / word valid; registered.
- `busy`  out  1  high in RUN and CSUM.
- `done`  out  1  one-cycle pulse in DONE.
- `words_sent`  out  LEN_W+1  words accepted in the current or last burst, payload plus checksum; held until the next start.

## Operation
- FSM states: IDLE, RUN, CSUM (present only with CHECKSUM_EN), DONE.
- IDLE behaviour:
  - `start=1` at an edge latches `burst_len`, `seed` and `step`.
  - At that edge: `data_1<=seed`, `data_1_en<=1`, remaining count `<=burst_len`, `words_sent<=0`, checksum `<=0`, state goes to RUN.
- RUN behaviour:
  - On each accepted edge: `words_sent++` and `checksum^=data_1`.
  - If remaining is not 0: `data_1<=data_1+step` (mod 2^DATA_W), `remaining--`.
  - If remaining is 0, with CHECKSUM_EN: state goes to CSUM, `data_1<=checksum^data_1`, `data_1_en` stays 1.
  - If remaining is 0, without CHECKSUM_EN: state goes to DONE, `data_1_en<=0`.
- Stall: while `buffer_full=1`, `data_1`, `data_1_en` and all counters hold unchanged. There is no timeout.
- CSUM: on the accepted edge, `words_sent++`, `data_1_en<=0`, state goes to DONE.
- DONE: `done=1` for exactly one cycle, then IDLE unconditionally.
- `start` is ignored outside IDLE, including in DONE. It is not queued.
- Reset values: state IDLE; `data_1=0`, `data_1_en=0`, `busy=0`, `done=0`, `words_sent=0`.
- Reset mid-burst: all outputs drop to their reset values asynchronously. A partial burst is abandoned, and the words already accepted stay in the FIFO.
- Width rules: `words_sent` never wraps. Its maximum is 2^LEN_W+1, which fits in LEN_W+1 bits for LEN_W≥1. The data addition truncates silently.

## Timing
- Latency: `start` is sampled at edge T, and the first word is valid after T.
- Unstalled burst of N payload words:
  - `data_1_en` is high for N cycles, or N+1 with the checksum.
  - `done` is high in the cycle after the last acceptance.
  - `busy` falls at that same edge.
- Back-to-back bursts: the minimum gap between the last word of one burst and the first word of the next is 2 cycles (DONE, then IDLE sampling `start`).
- `buffer_full` is used combinationally only in the accept qualifier. No output depends combinationally on any input.

## Configuration
- `BURST_WRITER_CHECKSUM_EN` defined: CSUM state is compiled in. Every burst carries one trailing word equal to the XOR of all its payload words, under the same handshake.
- Not defined: the CSUM state and checksum register are absent, the burst is payload only, and `words_sent` max is 2^LEN_W.

## Structure
- Package `burst_writer_pkg` holds:
  - the state enum (IDLE/RUN/CSUM/DONE);
  - default `DATA_W` and `LEN_W` constants;
  - the reset value constant for `data_1`.
- Single module. The XOR accumulator and data incrementer are small and stay inline; no sub-module is warranted.

## Test plan
- Reset, then `start`, `burst_len=3`, `seed=0x0010`, `step=0x0002`, `buffer_full=0` → `data_1` is 0x0010, 0x0012, 0x0014, 0x0016 on 4 consecutive cycles; with the checksum, a 5th word 0x0000; `done` pulses once; `words_sent` is 4 (5 with the checksum).
- Same burst with `buffer_full=1` for 3 cycles while 0x0012 is offered → 0x0012 is held for 3 extra cycles, no word is skipped or duplicated, and `done` is delayed by 3 cycles.
- Wrap-around: `seed=0xFFFF`, `step=0x0001`, `burst_len=1` → words 0xFFFF, 0x0000; with the checksum, trailing word 0xFFFF.
- Maximum burst: `burst_len=15` → 16 payload words; `words_sent` reads 16, or 17 with the checksum.
- `start` held high through RUN and DONE → exactly one burst per IDLE sampling; the next burst begins 2 cycles after the last word.
- `rst_n` asserted low mid-burst (after 2 words) → `data_1_en`, `busy` and `done` go to 0 immediately; after release, a new `start` begins a fresh burst from its own `seed`.
